// File: rtl/reg_stage_pkg.sv
// rtl/reg_stage_pkg.sv - shared parameters and packed-port slice helpers for the register read stage
package reg_stage_pkg;

    localparam int DEF_DATA_W  = 64;
    localparam int DEF_NREGS   = 32;
    localparam int DEF_NRD     = 2;
    localparam int DEF_ZERO_R0 = 1;
    localparam int WB_ADDR_W   = 5;
    localparam int WB_IMM_W    = 12;

    // Keep at least one address bit so degenerate register counts still elaborate.
    function automatic int calc_addr_w(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_array.sv
// rtl/regfile_array.sv - 1W / NRD-R register array with combinational read and synchronous clear
module regfile_array
    import reg_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = DEF_NRD,
    parameter int ADDR_W = calc_addr_w(DEF_NREGS)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < NREGS)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[slice_lo(k, ADDR_W) +: ADDR_W];
        assign rdata[slice_lo(k, DATA_W) +: DATA_W] =
            (32'(ra) < NREGS) ? mem_q[ra] : '0;
    end

endmodule

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - operand read stage with two-stage write bypass and a one-entry output register
module reg_read_stage
    import reg_stage_pkg::*;
#(
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  NREGS   = DEF_NREGS,
    parameter int  NRD     = DEF_NRD,
    parameter int  ZERO_R0 = DEF_ZERO_R0,
    localparam int ADDR_W  = calc_addr_w(NREGS)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WB_ADDR_W-1:0]  wb_addr,
    input  logic [WB_IMM_W-1:0]   wb_imm,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NRD*DATA_W-1:0] out_data,
    output logic [WB_ADDR_W-1:0]  out_wb_addr,
    output logic [WB_IMM_W-1:0]   out_wb_imm
);

    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]     pend_addr_q,  pend_addr_d;
    logic [DATA_W-1:0]     pend_data_q,  pend_data_d;
    logic                  out_valid_q,  out_valid_d;
    logic [NRD*DATA_W-1:0] out_data_q,   out_data_d;
    logic [WB_ADDR_W-1:0]  out_wb_addr_q, out_wb_addr_d;
    logic [WB_IMM_W-1:0]   out_wb_imm_q,  out_wb_imm_d;

    logic                  wr_keep;
    logic                  accept;
    logic [NRD*DATA_W-1:0] arr_rdata;
    logic [NRD*DATA_W-1:0] rd_ops;

    // Writes to the hardwired zero register or past the array end never reach the pending slot.
    assign wr_keep = wr_en
                   && !((ZERO_R0 != 0) && (wr_addr == '0))
                   && (32'(wr_addr) < NREGS);

    always_comb begin
        pend_valid_d = wr_keep;
        pend_addr_d  = wr_en ? wr_addr : pend_addr_q;
        pend_data_d  = wr_en ? wr_data : pend_data_q;
    end

    regfile_array #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .NRD    (NRD),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (pend_valid_q),
        .waddr (pend_addr_q),
        .wdata (pend_data_q),
        .raddr (rd_addr),
        .rdata (arr_rdata)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_byp
        logic [ADDR_W-1:0] ra;
        logic              ra_zero;
        logic [DATA_W-1:0] op;

        assign ra      = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
        assign ra_zero = (32'(ra) >= NREGS) || ((ZERO_R0 != 0) && (ra == '0));

        // Youngest write wins: live request, then the pending slot, then the array.
        always_comb begin
            if (ra_zero) begin
                op = '0;
            end else if (wr_en && (wr_addr == ra)) begin
                op = wr_data;
            end else if (pend_valid_q && (pend_addr_q == ra)) begin
                op = pend_data_q;
            end else begin
                op = arr_rdata[slice_lo(k, DATA_W) +: DATA_W];
            end
        end

        assign rd_ops[slice_lo(k, DATA_W) +: DATA_W] = op;
    end

    assign in_ready = rst || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_wb_addr_d = out_wb_addr_q;
        out_wb_imm_d  = out_wb_imm_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_data_d    = rd_ops;
            out_wb_addr_d = wb_addr;
            out_wb_imm_d  = wb_imm;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_wb_addr_q <= '0;
            out_wb_imm_q  <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_wb_addr_q <= out_wb_addr_d;
            out_wb_imm_q  <= out_wb_imm_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_wb_addr = out_wb_addr_q;
    assign out_wb_imm  = out_wb_imm_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - self-checking bench for reg_read_stage against an architectural register model
module tb_reg_read_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [9:0]   rd_addr;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   wb_addr;
    logic [11:0]  wb_imm;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_wb_addr;
    logic [11:0]  out_wb_imm;

    int checks = 0;
    int errors = 0;

    // Architectural view: a write is visible to a read in the same cycle.
    logic [63:0]  model [32];
    logic         m_valid;
    logic [127:0] m_data;
    logic [4:0]   m_wb_addr;
    logic [11:0]  m_wb_imm;

    always #5 clk = ~clk;

    reg_read_stage dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wb_addr     (wb_addr),
        .wb_imm      (wb_imm),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_wb_addr (out_wb_addr),
        .out_wb_imm  (out_wb_imm)
    );

    task automatic tick();
        logic acc;
        if (rst) begin
            foreach (model[i]) model[i] = '0;
            m_valid   = 1'b0;
            m_data    = '0;
            m_wb_addr = '0;
            m_wb_imm  = '0;
        end else begin
            if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
            acc = in_valid && (!m_valid || out_ready) && !flush;
            if (acc) begin
                m_data    = {model[rd_addr[9:5]], model[rd_addr[4:0]]};
                m_wb_addr = wb_addr;
                m_wb_imm  = wb_imm;
                m_valid   = 1'b1;
            end else if (flush || out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        wr_addr = 5'd4; wr_data = 64'h1234; rd_addr = '0; wb_addr = '0; wb_imm = '0;
        tick(); tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'd0 || out_wb_addr !== 5'd0 || out_wb_imm !== 12'd0) begin
            errors++; $display("FAIL reset_outputs: got v=%b d=%h wa=%h wi=%h expected all zero",
                               out_valid, out_data, out_wb_addr, out_wb_imm);
        end
        rst = 1'b0; idle();
    endtask

    task automatic test_zero_distance();
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hA5;
        in_valid = 1'b1; rd_addr = {5'd5, 5'd5}; wb_addr = 5'd17; wb_imm = 12'h3C1;
        tick(); idle();
        checks++;
        if (out_valid !== 1'b1 || out_data[63:0] !== 64'hA5) begin
            errors++; $display("FAIL zero_distance: got v=%b d0=%h expected v=1 d0=a5", out_valid, out_data[63:0]);
        end
        checks++;
        if (out_data !== m_data || out_wb_addr !== m_wb_addr || out_wb_imm !== m_wb_imm) begin
            errors++; $display("FAIL zero_distance_model: got %h/%h/%h expected %h/%h/%h",
                               out_data, out_wb_addr, out_wb_imm, m_data, m_wb_addr, m_wb_imm);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h11;
        tick();
        wr_data = 64'h22; in_valid = 1'b1; rd_addr = {5'd3, 5'd3};
        tick(); idle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {64'h22, 64'h22}) begin
            errors++; $display("FAIL b2b_t1: got v=%b d=%h expected both 22", out_valid, out_data);
        end
        tick();
        in_valid = 1'b1; rd_addr = {5'd3, 5'd3};
        tick(); idle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {64'h22, 64'h22}) begin
            errors++; $display("FAIL b2b_t3: got v=%b d=%h expected both 22", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hFF;
        tick(); idle();
        in_valid = 1'b1; rd_addr = {5'd0, 5'd0};
        tick(); idle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 128'd0) begin
            errors++; $display("FAIL zero_reg: got v=%b d=%h expected 0", out_valid, out_data);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hEE;
        in_valid = 1'b1; rd_addr = {5'd0, 5'd0};
        tick(); idle();
        checks++;
        if (out_data !== 128'd0) begin
            errors++; $display("FAIL zero_reg_live: got %h expected 0", out_data);
        end
        tick();
    endtask

    task automatic test_stall();
        idle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h7;
        tick(); idle();
        in_valid = 1'b1; rd_addr = {5'd7, 5'd7};
        tick();
        for (int c = 0; c < 3; c++) begin
            out_ready = 1'b0; in_valid = 1'b1; rd_addr = {5'd7, 5'd7};
            wr_en = (c == 0); wr_addr = 5'd7; wr_data = 64'h9;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data[63:0] !== 64'h7) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b d0=%h expected v=1 d0=7", c, out_valid, out_data[63:0]);
            end
        end
        idle();
        in_valid = 1'b1; rd_addr = {5'd7, 5'd7};
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data[63:0] !== 64'h9 || out_data !== m_data) begin
            errors++; $display("FAIL release_data: got %h expected %h", out_data, m_data);
        end
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        idle();
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; rd_addr = {5'd1, 5'd1};
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'hDEAD_BEEF_1234_5678;
        tick(); idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %b expected 0", out_valid);
        end
        in_valid = 1'b1; rd_addr = {5'd10, 5'd10};
        tick(); idle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== {2{64'hDEAD_BEEF_1234_5678}}) begin
            errors++; $display("FAIL flush_write_kept: got v=%b d=%h expected deadbeef12345678 x2", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            wr_en     = $urandom_range(0, 1);
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 7) == 0) rd_addr = 10'($urandom);
            wb_addr   = 5'($urandom);
            wb_imm    = 12'($urandom);
            flush     = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, (!m_valid || out_ready));
            end
            tick();
            checks++;
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, out_valid, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (out_data !== m_data || out_wb_addr !== m_wb_addr || out_wb_imm !== m_wb_imm) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h/%h/%h expected %h/%h/%h", n,
                                       out_data, out_wb_addr, out_wb_imm, m_data, m_wb_addr, m_wb_imm);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
        tick(); idle();
        in_valid = 1'b1; rd_addr = {5'd9, 5'd9};
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'h66;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data[63:0] !== 64'h55) begin
            errors++; $display("FAIL pre_reset: got v=%b d0=%h expected v=1 d0=55", out_valid, out_data[63:0]);
        end
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd13; wr_data = 64'h77;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; idle();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b d=%h expected v=0 d=0", out_valid, out_data);
        end
        for (int r = 0; r < 32; r += 2) begin
            in_valid = 1'b1; rd_addr = {5'(r + 1), 5'(r)};
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 128'd0 || out_data !== m_data) begin
                errors++; $display("FAIL post_reset_r%0d: got v=%b d=%h expected v=1 d=0", r, out_valid, out_data);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_distance();
        test_back_to_back();
        test_zero_reg();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
